as_gpio_ctrl: RTL and testbench
===============================

Name: as_gpio_ctrl

Overview:
Memory-mapped GPIO and test-status controller inside as_top_mem, sitting between the core's data-bus port and the top-level gpio_io pads and cs_o pin.
- Holds the output, direction and interrupt registers.
- Synchronises pad inputs and flags rising edges.
- Pulses cs_o after every DATA_OUT write, so an external observer samples gpio only while it is stable.

Parameters:
NR_GPIOS, nr_gpios (as_pack), number of GPIO lines, 1..64
XLEN, 64, bus data width
ADDR_W, 6, byte-offset width of the register window
CS_CYCLES, 2, cycles cs_o stays high after a DATA_OUT write, >=1

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-low
req_i  in  1  bus access strobe, one cycle per access
we_i  in  1  1=write, 0=read, valid with req_i
addr_i  in  ADDR_W  byte offset, valid with req_i
wdata_i  in  XLEN  write data, valid with req_i
rdata_o  out  XLEN  read data, valid when ack_o=1
ack_o  out  1  access complete
gpio_i  in  NR_GPIOS  pad input values (asynchronous)
gpio_o  out  NR_GPIOS  pad output values
gpio_oe_o  out  NR_GPIOS  per-bit output enable (top level builds the tri-state)
cs_o  out  1  data-valid strobe to the external observer
irq_o  out  1  level interrupt

Behaviour:
- Register map (8-byte aligned offsets):
  - 0x00 DATA_OUT RW
  - 0x08 DIR RW, 1=output
  - 0x10 DATA_IN RO
  - 0x18 IRQ_EN RW
  - 0x20 IRQ_STAT RW1C
  - 0x28 CS_CNT RO, current cs countdown
- Reset (rst_i low, async): every register, synchroniser flop, counter, ack_o, rdata_o, cs_o and irq_o go to 0. gpio_oe_o=0, so all pads are inputs. Deassertion takes effect on the next clk_i rising edge.
- Bus handshake:
  - ack_o is high exactly one cycle after each req_i cycle.
  - Back-to-back req_i every cycle is legal; each one gets its own ack.
  - Writes take effect at the req_i edge.
  - rdata_o is registered and valid with ack_o; it is 0 whenever ack_o=0.
  - addr_i[2:0] is ignored.
  - Unmapped offset: read returns 0, write is dropped, ack still given.
- Width rules:
  - Writes use wdata_i[NR_GPIOS-1:0]; bits above NR_GPIOS are ignored.
  - Reads zero-extend to XLEN.
  - Writes to DATA_IN or CS_CNT are ignored.
- gpio_o = DATA_OUT register. gpio_oe_o = DIR register. Both are direct flop outputs.
- Input path:
  - gpio_i passes through a 2-flop synchroniser (sync_q). DATA_IN = sync_q, so latency from pad to DATA_IN is 2 cycles.
  - A third flop prev_q gives rise = sync_q & ~prev_q.
- Interrupts:
  - IRQ_STAT[n] is set when rise[n] & IRQ_EN[n].
  - A write clears the bits where wdata_i=1.
  - If set and clear hit the same bit in the same cycle, set wins.
  - irq_o = registered OR of IRQ_STAT, one cycle after the status update.
  - Clearing IRQ_EN does not clear pending status bits.
- cs state machine (IDLE, HOLD):
  - IDLE: cs_o=0. A DATA_OUT write loads cnt=CS_CYCLES and moves to HOLD; cs_o rises on the cycle after the write edge, when gpio_o is already updated.
  - HOLD: cs_o=1 and cnt decrements each cycle. At cnt==1 the block returns to IDLE, giving cs_o high for exactly CS_CYCLES cycles.
  - A DATA_OUT write while in HOLD updates gpio_o, reloads cnt=CS_CYCLES and stays in HOLD. cs_o stays high continuously, with no low gap.
  - Writes to other registers never touch cs.
- Reset mid-HOLD: cs_o drops immediately (asynchronous) and the state goes to IDLE.

Decomposition:
- as_pack additions:
  - GPIO_OFS_DATA_OUT, _DIR, _DATA_IN, _IRQ_EN, _IRQ_STAT, _CS_CNT localparams
  - GPIO_CS_CYCLES default
  - typedef enum logic {CS_IDLE, CS_HOLD} cs_state_t
  - nr_gpios already exists there.
- Sub-module as_sync2: parameterised-width 2-flop synchroniser with async active-low reset, reused by other peripherals.

Test Plan:
1. Reset value check: hold rst_i low 3 cycles, then release. Required: gpio_oe_o=0, gpio_o=0, cs_o=0, irq_o=0, ack_o=0; read DATA_OUT returns 0 with ack one cycle after req.
2. cs pulse timing: write DIR=0xFF, then DATA_OUT=0x1. Required: gpio_o=0x1 the cycle after the write; cs_o high exactly 2 cycles, starting that same cycle. Then write DATA_OUT=0x7: gpio_o=0x7 with a fresh 2-cycle cs pulse.
3. Retrigger during HOLD: write DATA_OUT=0x3 on two consecutive cycles. Required: cs_o high 3 cycles continuously, with no low gap.
4. Edge interrupt and W1C: set IRQ_EN=0x4, drive gpio_i[2] 0->1. Required: DATA_IN bit2=1 after 2 cycles; IRQ_STAT=0x4 and irq_o=1 one cycle later.
   - Write IRQ_STAT=0x4 → irq_o=0.
   - Repeat with the clear coinciding with a new rise → bit stays 1.
5. Address and width edge cases: read 0x30 → 0; write DATA_IN=0xFF → DATA_IN unchanged; with NR_GPIOS=8, write DATA_OUT=0xFFFF_FFFF_FFFF_FFFF → read returns 0xFF.
6. Async reset mid-pulse: assert rst_i mid-HOLD, between clock edges. Required: cs_o, gpio_o and gpio_oe_o go to 0 before the next clock edge; after release no cs pulse appears until a new DATA_OUT write.

Source files
------------

// File: rtl/as_pack.sv
// Shared constants and types for the as_top_mem peripherals.
// GPIO register offsets, cs hold default and cs FSM states.
package as_pack;

  localparam int unsigned nr_gpios = 8;

  localparam logic [5:0] GPIO_OFS_DATA_OUT = 6'h00;
  localparam logic [5:0] GPIO_OFS_DIR      = 6'h08;
  localparam logic [5:0] GPIO_OFS_DATA_IN  = 6'h10;
  localparam logic [5:0] GPIO_OFS_IRQ_EN   = 6'h18;
  localparam logic [5:0] GPIO_OFS_IRQ_STAT = 6'h20;
  localparam logic [5:0] GPIO_OFS_CS_CNT   = 6'h28;

  localparam int unsigned GPIO_CS_CYCLES = 2;

  typedef enum logic {
    CS_IDLE,
    CS_HOLD
  } cs_state_t;

endpackage

// File: rtl/as_sync2.sv
// Two-flop synchroniser for asynchronous inputs.
// Width is a parameter so other peripherals can reuse it.
module as_sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/as_gpio_ctrl.sv
// Memory-mapped GPIO with edge interrupts and a cs_o strobe
// that frames every DATA_OUT update for an external observer.
module as_gpio_ctrl
  import as_pack::*;
#(
  parameter int unsigned NR_GPIOS  = nr_gpios,
  parameter int unsigned XLEN      = 64,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned CS_CYCLES = GPIO_CS_CYCLES
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [XLEN-1:0]     wdata_i,
  output logic [XLEN-1:0]     rdata_o,
  output logic                ack_o,
  input  logic [NR_GPIOS-1:0] gpio_i,
  output logic [NR_GPIOS-1:0] gpio_o,
  output logic [NR_GPIOS-1:0] gpio_oe_o,
  output logic                cs_o,
  output logic                irq_o
);

  localparam int unsigned CNT_W = $clog2(CS_CYCLES + 1);

  logic [NR_GPIOS-1:0] dout_q, dout_d;
  logic [NR_GPIOS-1:0] dir_q, dir_d;
  logic [NR_GPIOS-1:0] ien_q, ien_d;
  logic [NR_GPIOS-1:0] ist_q, ist_d;
  logic [NR_GPIOS-1:0] prev_q;
  logic [NR_GPIOS-1:0] sync;
  logic [NR_GPIOS-1:0] rise;
  logic [NR_GPIOS-1:0] wd;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic [XLEN-1:0]     rval;
  logic                ack_q;
  logic                irq_q;
  cs_state_t           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [ADDR_W-1:0] ofs;
  logic hit_dout, hit_dir, hit_din;
  logic hit_ien, hit_ist, hit_cnt;
  logic wr, rd, dout_wr;
  logic unused_ok;

  as_sync2 #(
    .W(NR_GPIOS)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_i),
    .d_i   (gpio_i),
    .q_o   (sync)
  );

  // Low address bits select bytes within a register and are ignored.
  assign ofs      = {addr_i[ADDR_W-1:3], 3'b000};
  assign hit_dout = ofs == ADDR_W'(GPIO_OFS_DATA_OUT);
  assign hit_dir  = ofs == ADDR_W'(GPIO_OFS_DIR);
  assign hit_din  = ofs == ADDR_W'(GPIO_OFS_DATA_IN);
  assign hit_ien  = ofs == ADDR_W'(GPIO_OFS_IRQ_EN);
  assign hit_ist  = ofs == ADDR_W'(GPIO_OFS_IRQ_STAT);
  assign hit_cnt  = ofs == ADDR_W'(GPIO_OFS_CS_CNT);

  assign wr      = req_i & we_i;
  assign rd      = req_i & ~we_i;
  assign dout_wr = wr & hit_dout;
  assign wd      = wdata_i[NR_GPIOS-1:0];
  assign rise    = sync & ~prev_q;

  assign unused_ok = ^{addr_i[2:0], wdata_i};

  always_comb begin
    rval = '0;
    unique case (1'b1)
      hit_dout: rval = XLEN'(dout_q);
      hit_dir:  rval = XLEN'(dir_q);
      hit_din:  rval = XLEN'(sync);
      hit_ien:  rval = XLEN'(ien_q);
      hit_ist:  rval = XLEN'(ist_q);
      hit_cnt:  rval = XLEN'(cnt_q);
      default:  rval = '0;
    endcase
  end

  // Set is OR-ed in after the W1C mask so a coincident rise wins.
  always_comb begin
    dout_d  = dout_wr ? wd : dout_q;
    dir_d   = (wr & hit_dir) ? wd : dir_q;
    ien_d   = (wr & hit_ien) ? wd : ien_q;
    ist_d   = ist_q;
    if (wr & hit_ist) begin
      ist_d = ist_q & ~wd;
    end
    ist_d   = ist_d | (rise & ien_q);
    rdata_d = rd ? rval : '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CS_IDLE: begin
        if (dout_wr) begin
          state_d = CS_HOLD;
          cnt_d   = CNT_W'(CS_CYCLES);
        end
      end
      CS_HOLD: begin
        if (dout_wr) begin
          cnt_d = CNT_W'(CS_CYCLES);
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = CS_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = CS_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dout_q  <= '0;
      dir_q   <= '0;
      ien_q   <= '0;
      ist_q   <= '0;
      prev_q  <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      irq_q   <= 1'b0;
      state_q <= CS_IDLE;
      cnt_q   <= '0;
    end else begin
      dout_q  <= dout_d;
      dir_q   <= dir_d;
      ien_q   <= ien_d;
      ist_q   <= ist_d;
      prev_q  <= sync;
      rdata_q <= rdata_d;
      ack_q   <= req_i;
      irq_q   <= |ist_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gpio_o    = dout_q;
  assign gpio_oe_o = dir_q;
  assign rdata_o   = rdata_q;
  assign ack_o     = ack_q;
  assign irq_o     = irq_q;
  assign cs_o      = state_q == CS_HOLD;

endmodule

// File: tb/tb_as_gpio_ctrl.sv
// Directed testbench for as_gpio_ctrl (NR_GPIOS=8, CS_CYCLES=2).
// Inputs change on falling edges; outputs are sampled there too.
module tb_as_gpio_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [5:0]  addr_i = '0;
  logic [63:0] wdata_i = '0;
  logic [63:0] rdata_o;
  logic        ack_o;
  logic [7:0]  gpio_i = '0;
  logic [7:0]  gpio_o;
  logic [7:0]  gpio_oe_o;
  logic        cs_o;
  logic        irq_o;

  int tests = 0;
  int fails = 0;

  localparam logic [5:0] A_DOUT = 6'h00;
  localparam logic [5:0] A_DIR  = 6'h08;
  localparam logic [5:0] A_DIN  = 6'h10;
  localparam logic [5:0] A_IEN  = 6'h18;
  localparam logic [5:0] A_IST  = 6'h20;
  localparam logic [5:0] A_CNT  = 6'h28;

  as_gpio_ctrl #(
    .NR_GPIOS (8),
    .XLEN     (64),
    .ADDR_W   (6),
    .CS_CYCLES(2)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rdata_o  (rdata_o),
    .ack_o    (ack_o),
    .gpio_i   (gpio_i),
    .gpio_o   (gpio_o),
    .gpio_oe_o(gpio_oe_o),
    .cs_o     (cs_o),
    .irq_o    (irq_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [5:0] a, input logic [63:0] d);
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
    @(negedge clk_i);
    req_i = 1'b0; we_i = 1'b0; wdata_i = '0;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic a1,
                          output logic a2, output logic [63:0] d);
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; addr_i = a;
    @(negedge clk_i);
    req_i = 1'b0;
    a1 = ack_o;
    d  = rdata_o;
    @(negedge clk_i);
    a2 = ack_o;
  endtask

  task automatic test_reset;
    logic a1, a2;
    logic [63:0] d;
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    tests++;
    if ({gpio_oe_o, gpio_o} !== 16'h0) begin
      fails++;
      $display("FAIL rst_pads: got %h want 0000", {gpio_oe_o, gpio_o});
    end
    tests++;
    if ({cs_o, irq_o, ack_o} !== 3'b000) begin
      fails++;
      $display("FAIL rst_flags: got %b want 000", {cs_o, irq_o, ack_o});
    end
    rst_i = 1'b1;
    tests++;
    if (ack_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_ack_idle: got %b want 0", ack_o);
    end
    bus_read(A_DOUT, a1, a2, d);
    tests++;
    if ({a1, a2} !== 2'b10) begin
      fails++;
      $display("FAIL rst_rd_ack: got %b want 10", {a1, a2});
    end
    tests++;
    if (d !== 64'h0) begin
      fails++;
      $display("FAIL rst_rd_dout: got %h want 0", d);
    end
  endtask

  task automatic test_cs_pulse;
    logic [2:0] p;
    logic a1, a2;
    logic [63:0] d;
    bus_write(A_DIR, 64'hFF);
    tests++;
    if ({gpio_oe_o, cs_o} !== {8'hFF, 1'b0}) begin
      fails++;
      $display("FAIL cs_dir: got %h/%b want ff/0", gpio_oe_o, cs_o);
    end
    bus_write(A_DOUT, 64'h1);
    tests++;
    if (gpio_o !== 8'h01) begin
      fails++;
      $display("FAIL cs_gpio1: got %h want 01", gpio_o);
    end
    p[2] = cs_o;
    @(negedge clk_i); p[1] = cs_o;
    @(negedge clk_i); p[0] = cs_o;
    tests++;
    if (p !== 3'b110) begin
      fails++;
      $display("FAIL cs_pulse1: got %b want 110", p);
    end
    repeat (2) @(negedge clk_i);
    bus_write(A_DOUT, 64'h7);
    tests++;
    if (gpio_o !== 8'h07) begin
      fails++;
      $display("FAIL cs_gpio7: got %h want 07", gpio_o);
    end
    p[2] = cs_o;
    @(negedge clk_i); p[1] = cs_o;
    @(negedge clk_i); p[0] = cs_o;
    tests++;
    if (p !== 3'b110) begin
      fails++;
      $display("FAIL cs_pulse7: got %b want 110", p);
    end
    repeat (2) @(negedge clk_i);
    bus_write(A_DOUT, 64'h2);
    bus_read(A_CNT, a1, a2, d);
    tests++;
    if (d !== 64'h1) begin
      fails++;
      $display("FAIL cs_cnt_hold: got %h want 1", d);
    end
    bus_read(A_CNT, a1, a2, d);
    tests++;
    if (d !== 64'h0) begin
      fails++;
      $display("FAIL cs_cnt_idle: got %h want 0", d);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] p;
    logic ak;
    repeat (2) @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; addr_i = A_DOUT; wdata_i = 64'h3;
    @(negedge clk_i);
    p[3] = cs_o;
    ak = ack_o;
    @(negedge clk_i);
    req_i = 1'b0; we_i = 1'b0; wdata_i = '0;
    p[2] = cs_o;
    tests++;
    if ({ak, ack_o} !== 2'b11) begin
      fails++;
      $display("FAIL b2b_ack: got %b want 11", {ak, ack_o});
    end
    @(negedge clk_i); p[1] = cs_o;
    @(negedge clk_i); p[0] = cs_o;
    tests++;
    if (p !== 4'b1110) begin
      fails++;
      $display("FAIL b2b_cs: got %b want 1110", p);
    end
    tests++;
    if (gpio_o !== 8'h03) begin
      fails++;
      $display("FAIL b2b_gpio: got %h want 03", gpio_o);
    end
  endtask

  task automatic test_data_in;
    logic a1, a2;
    logic [63:0] d;
    @(negedge clk_i);
    gpio_i = 8'h01;
    bus_read(A_DIN, a1, a2, d);
    tests++;
    if (d !== 64'h0) begin
      fails++;
      $display("FAIL din_early: got %h want 0", d);
    end
    @(negedge clk_i);
    gpio_i = 8'h03;
    @(negedge clk_i);
    bus_read(A_DIN, a1, a2, d);
    tests++;
    if (d !== 64'h3) begin
      fails++;
      $display("FAIL din_2cyc: got %h want 3", d);
    end
  endtask

  task automatic test_irq;
    logic [3:0] p;
    logic a1, a2;
    logic [63:0] d;
    bus_write(A_IEN, 64'h4);
    gpio_i = 8'h07;
    @(negedge clk_i); p[3] = irq_o;
    @(negedge clk_i); p[2] = irq_o;
    @(negedge clk_i); p[1] = irq_o;
    @(negedge clk_i); p[0] = irq_o;
    tests++;
    if (p !== 4'b0001) begin
      fails++;
      $display("FAIL irq_timing: got %b want 0001", p);
    end
    bus_read(A_IST, a1, a2, d);
    tests++;
    if (d !== 64'h4) begin
      fails++;
      $display("FAIL irq_stat: got %h want 4", d);
    end
    bus_read(A_DIN, a1, a2, d);
    tests++;
    if (d !== 64'h7) begin
      fails++;
      $display("FAIL irq_din: got %h want 7", d);
    end
    bus_write(A_IST, 64'h4);
    p[1] = irq_o;
    @(negedge clk_i); p[0] = irq_o;
    tests++;
    if (p[1:0] !== 2'b10) begin
      fails++;
      $display("FAIL irq_w1c: got %b want 10", p[1:0]);
    end
    gpio_i = 8'h03;
    repeat (4) @(negedge clk_i);
    gpio_i = 8'h07;
    @(negedge clk_i);
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; addr_i = A_IST; wdata_i = 64'h4;
    @(negedge clk_i);
    req_i = 1'b0; we_i = 1'b0; wdata_i = '0;
    bus_read(A_IST, a1, a2, d);
    tests++;
    if ({d, irq_o} !== {64'h4, 1'b1}) begin
      fails++;
      $display("FAIL irq_set_wins: got %h/%b want 4/1", d, irq_o);
    end
    bus_write(A_IEN, 64'h0);
    bus_read(A_IST, a1, a2, d);
    tests++;
    if (d !== 64'h4) begin
      fails++;
      $display("FAIL irq_en_keep: got %h want 4", d);
    end
    bus_write(A_IST, 64'hFF);
    repeat (2) @(negedge clk_i);
    tests++;
    if (irq_o !== 1'b0) begin
      fails++;
      $display("FAIL irq_final_clr: got %b want 0", irq_o);
    end
  endtask

  task automatic test_edges;
    logic a1, a2;
    logic [63:0] d;
    bus_read(6'h30, a1, a2, d);
    tests++;
    if ({a1, d} !== {1'b1, 64'h0}) begin
      fails++;
      $display("FAIL unmapped_rd: got %b/%h want 1/0", a1, d);
    end
    bus_write(6'h38, 64'hFF);
    tests++;
    if ({gpio_o, gpio_oe_o, cs_o} !== {8'h03, 8'hFF, 1'b0}) begin
      fails++;
      $display("FAIL unmapped_wr: got %h %h %b want 03 ff 0",
               gpio_o, gpio_oe_o, cs_o);
    end
    bus_write(A_DIN, 64'hFF);
    bus_read(A_DIN, a1, a2, d);
    tests++;
    if (d !== 64'h7) begin
      fails++;
      $display("FAIL din_ro: got %h want 7", d);
    end
    bus_write(A_CNT, 64'h3);
    tests++;
    if (cs_o !== 1'b0) begin
      fails++;
      $display("FAIL cnt_ro_cs: got %b want 0", cs_o);
    end
    bus_read(6'h0B, a1, a2, d);
    tests++;
    if (d !== 64'hFF) begin
      fails++;
      $display("FAIL addr_lowbits: got %h want ff", d);
    end
    bus_write(A_DOUT, 64'hFFFF_FFFF_FFFF_FFFF);
    bus_read(A_DOUT, a1, a2, d);
    tests++;
    if (d !== 64'h0000_0000_0000_00FF) begin
      fails++;
      $display("FAIL width_rd: got %h want ff", d);
    end
  endtask

  task automatic test_async_reset;
    int hi;
    logic a1, a2;
    logic [63:0] d;
    repeat (3) @(negedge clk_i);
    bus_write(A_DOUT, 64'h5A);
    tests++;
    if (cs_o !== 1'b1) begin
      fails++;
      $display("FAIL ar_pre_cs: got %b want 1", cs_o);
    end
    #2;
    rst_i = 1'b0;
    #1;
    tests++;
    if ({cs_o, gpio_o, gpio_oe_o} !== 17'h0) begin
      fails++;
      $display("FAIL ar_async: got %b %h %h want 0 00 00",
               cs_o, gpio_o, gpio_oe_o);
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (cs_o) hi++;
    end
    tests++;
    if (hi !== 0) begin
      fails++;
      $display("FAIL ar_no_pulse: got %0d want 0", hi);
    end
    bus_read(A_DIR, a1, a2, d);
    tests++;
    if (d !== 64'h0) begin
      fails++;
      $display("FAIL ar_dir: got %h want 0", d);
    end
    bus_write(A_DOUT, 64'h1);
    tests++;
    if ({cs_o, gpio_o} !== {1'b1, 8'h01}) begin
      fails++;
      $display("FAIL ar_new_pulse: got %b/%h want 1/01", cs_o, gpio_o);
    end
  endtask

  initial begin
    test_reset();
    test_cs_pulse();
    test_back_to_back();
    test_data_in();
    test_irq();
    test_edges();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
